// File: rtl/data_io_driver.sv
// Host-side driver for data_io: turns a valid/ready command into the 23-bit pin word
// (opcode, parity strobe, payload) and captures the 6-bit reply after a fixed latency.
module data_io_driver #(
    parameter int SETUP_CYC = 1,
    parameter int RESP_LAT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_poll,
    input  logic [1:0]  cmd_opcode,
    input  logic [18:0] cmd_data,
    output logic [22:0] pin_out,
    input  logic [5:0]  pin_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic [3:0]  rsp_result,
    output logic        busy
);

    localparam int MAX_CNT = (SETUP_CYC > RESP_LAT) ? SETUP_CYC : RESP_LAT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [22:0]   pin_reg, pin_next;
    logic          phase_reg, phase_next;
    logic          rsp_valid_reg, rsp_valid_next;
    logic [1:0]    status_reg, status_next;
    logic [3:0]    result_reg, result_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pin_reg       <= '0;
            phase_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            status_reg    <= '0;
            result_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pin_reg       <= pin_next;
            phase_reg     <= phase_next;
            rsp_valid_reg <= rsp_valid_next;
            status_reg    <= status_next;
            result_reg    <= result_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pin_next       = pin_reg;
        phase_next     = phase_reg;
        rsp_valid_next = rsp_valid_reg;
        status_next    = status_reg;
        result_next    = result_reg;
        cmd_ready      = (state_reg == IDLE) && !rsp_valid_reg;

        if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_poll) begin
                        cnt_next   = CW'(RESP_LAT);
                        state_next = WAIT;
                    end else begin
                        // Parity bits stay put until the setup window has elapsed.
                        pin_next   = {cmd_opcode, pin_reg[20:19], cmd_data};
                        cnt_next   = CW'(SETUP_CYC);
                        state_next = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt_reg == CW'(1)) begin
                    // Strobe always has bit 1 set and differs from the previous parity.
                    pin_next[20:19] = {1'b1, ~phase_reg};
                    phase_next      = ~phase_reg;
                    cnt_next        = CW'(RESP_LAT);
                    state_next      = WAIT;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            WAIT: begin
                if (cnt_reg == CW'(1)) begin
                    status_next    = pin_in[5:4];
                    result_next    = pin_in[3:0];
                    rsp_valid_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pin_out    = pin_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_status = status_reg;
    assign rsp_result = result_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_data_io_driver.sv
// Directed bench for data_io_driver: expected responses are queued when a command is
// issued and compared when rsp_valid appears; outputs are sampled on the falling edge.
module tb_data_io_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_poll;
    logic [1:0]  cmd_opcode;
    logic [18:0] cmd_data;
    logic [22:0] pin_out;
    logic [5:0]  pin_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [3:0]  rsp_result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tcyc     = 0;
    logic [5:0] exp_q[$];

    data_io_driver #(.SETUP_CYC(1), .RESP_LAT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_poll   (cmd_poll),
        .cmd_opcode (cmd_opcode),
        .cmd_data   (cmd_data),
        .pin_out    (pin_out),
        .pin_in     (pin_in),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        tcyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer a command in the current cycle (cycle 0) and advance to cycle 1.
    task automatic send(input string tag, input logic poll, input logic [1:0] op,
                        input logic [18:0] data, input logic [5:0] exp_rsp);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_poll   = poll;
        cmd_opcode = op;
        cmd_data   = data;
        exp_q.push_back(exp_rsp);
        cyc = 0;
        tick();
        cmd_valid = 1'b0;
        cmd_poll  = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid, checking latency and popping the scoreboard.
    task automatic wait_rsp(input string tag, input int exp_cyc);
        logic [5:0] e;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_cmd_ready_low"}, 32'(cmd_ready), 32'd0);
            tick();
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        if (rsp_valid === 1'b1) begin
            chk({tag, "_busy_at_rsp"}, 32'(busy), 32'd0);
            if (exp_q.size() == 0) begin
                chk({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_status"}, 32'(rsp_status), 32'(e[5:4]));
                chk({tag, "_result"}, 32'(rsp_result), 32'(e[3:0]));
            end
            $display("rsp %s: cycle=%0d status=%b result=%h", tag, cyc, rsp_status, rsp_result);
        end
    endtask

    initial begin
        logic [22:0] saved;
        logic        seen;
        int          t0;

        rst = 1'b1; cmd_valid = 1'b0; cmd_poll = 1'b0; cmd_opcode = '0;
        cmd_data = '0; pin_in = '0; rsp_ready = 1'b1;
        @(negedge clk);

        // Reset
        do_reset();
        chk("reset_pin_out", 32'(pin_out), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_fields", 32'({rsp_status, rsp_result}), 32'd0);

        // Single write
        pin_in = 6'b10_1100;
        send("single", 1'b0, 2'b01, 19'h5A5A5, 6'b10_1100);
        chk("single_c1_pin_out", 32'(pin_out), 32'({2'b01, 2'b00, 19'h5A5A5}));
        chk("single_c1_busy", 32'(busy), 32'd1);
        tick();
        chk("single_c2_parity", 32'(pin_out[20:19]), 32'(2'b11));
        wait_rsp("single", 6);
        tick();
        chk("single_rsp_cleared", 32'(rsp_valid), 32'd0);

        // Back-to-back writes from a fresh reset
        do_reset();
        t0 = tcyc;
        for (int i = 0; i < 3; i++) begin
            logic [5:0]  p;
            logic [1:0]  par;
            p   = 6'(7 * i + 5);
            par = (i == 1) ? 2'b10 : 2'b11;
            pin_in = p;
            chk("b2b_accept_cycle", 32'(tcyc - t0), 32'(7 * i));
            send("b2b", 1'b0, 2'b10, 19'(i + 1), p);
            tick();
            chk("b2b_parity", 32'(pin_out[20:19]), 32'(par));
            chk("b2b_data", 32'(pin_out[18:0]), 32'(i + 1));
            wait_rsp("b2b", 6);
            tick();
        end

        // Backpressure: response held while cmd_valid stays high with a new command
        rsp_ready = 1'b0;
        pin_in = 6'h2D;
        send("bp1", 1'b0, 2'b11, 19'h12345, 6'h2D);
        cmd_valid = 1'b1; cmd_opcode = 2'b00; cmd_data = 19'h00ABC;
        tick();
        chk("bp1_parity", 32'(pin_out[20:19]), 32'(2'b10));
        wait_rsp("bp1", 6);
        pin_in = 6'h0E;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_fields", 32'({rsp_status, rsp_result}), 32'h2D);
            chk("bp_hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_hold_pin_out", 32'(pin_out), 32'({2'b11, 2'b10, 19'h12345}));
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_cleared", 32'(rsp_valid), 32'd0);
        chk("bp_ready_again", 32'(cmd_ready), 32'd1);
        exp_q.push_back(6'h0E);
        cyc = 0;
        tick();
        cmd_valid = 1'b0;
        chk("bp2_c1_pin_out", 32'(pin_out), 32'({2'b00, 2'b10, 19'h00ABC}));
        wait_rsp("bp2", 6);
        tick();

        // Poll: pins untouched
        saved  = pin_out;
        pin_in = 6'h3F;
        send("poll", 1'b1, 2'b01, 19'h7FFFF, 6'h3F);
        chk("poll_c1_pin_out", 32'(pin_out), 32'(saved));
        wait_rsp("poll", 5);
        chk("poll_end_pin_out", 32'(pin_out), 32'(saved));
        tick();

        // Reset in cycle 1 of a write
        pin_in = 6'h15;
        send("midrst", 1'b0, 2'b10, 19'h0F0F0, 6'h15);
        void'(exp_q.pop_back());
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_pin_out", 32'(pin_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen |= rsp_valid;
            tick();
        end
        chk("midrst_no_response", 32'(seen), 32'd0);
        pin_in = 6'h21;
        send("postrst", 1'b0, 2'b01, 19'h00001, 6'h21);
        chk("postrst_c1_parity", 32'(pin_out[20:19]), 32'(2'b00));
        tick();
        chk("postrst_c2_parity", 32'(pin_out[20:19]), 32'(2'b11));
        wait_rsp("postrst", 6);
        tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
